// File: rtl/hazard_stall_ctrl.sv
// Decode-stage interlock: per-register busy scoreboard driving IF/ID stalls and
// EX bubbles, with external freeze, branch flush and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int NREG     = 4,
    parameter int ALU_LAT  = 2,
    parameter int LOAD_LAT = 3,
    parameter int PCW      = 16,
    localparam int RW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_use_a,
    input  logic            id_use_b,
    input  logic [RW-1:0]   id_ra,
    input  logic [RW-1:0]   id_rb,
    input  logic            id_wr_en,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_is_load,
    input  logic            ext_stall,
    input  logic            flush,
    input  logic            perf_clr,
    output logic            stall_if,
    output logic            stall_id,
    output logic            bubble_ex,
    output logic            issue,
    output logic [NREG-1:0] busy_mask,
    output logic [PCW-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        M_RUN,
        M_HAZARD,
        M_FLUSH,
        M_FREEZE
    } mode_t;

    localparam logic [1:0] ALU_L  = 2'(ALU_LAT);
    localparam logic [1:0] LOAD_L = 2'(LOAD_LAT);

    logic [1:0] cnt     [NREG];
    logic [1:0] cnt_nxt [NREG];
    logic [1:0] lat;
    logic       raw;
    logic       waw;
    logic       haz;
    mode_t      mode;

    always_comb begin
        lat  = id_is_load ? LOAD_L : ALU_L;
        raw  = (id_use_a && (cnt[id_ra] != '0)) || (id_use_b && (cnt[id_rb] != '0));
        waw  = id_wr_en && (cnt[id_rd] > lat);
        haz  = id_valid && (raw || waw);
        if (ext_stall)
            mode = M_FREEZE;
        else if (flush)
            mode = M_FLUSH;
        else if (haz)
            mode = M_HAZARD;
        else
            mode = M_RUN;
    end

    always_comb begin
        stall_if  = (mode == M_FREEZE) || (mode == M_HAZARD);
        stall_id  = (mode == M_FREEZE) || (mode == M_HAZARD);
        bubble_ex = (mode == M_FLUSH)  || (mode == M_HAZARD);
        issue     = (mode == M_RUN) && id_valid;
    end

    // Hazard checks above read the pre-update counts, so an issuing write to
    // its own source register never stalls itself.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt[r];
            if ((mode != M_FREEZE) && (cnt[r] != '0))
                cnt_nxt[r] = cnt[r] - 2'd1;
        end
        if (issue && id_wr_en && (lat != '0))
            cnt_nxt[id_rd] = lat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++)
                cnt[r] <= '0;
            busy_mask    <= '0;
            stall_cycles <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r]       <= cnt_nxt[r];
                busy_mask[r] <= (cnt_nxt[r] != '0);
            end
            if (perf_clr)
                stall_cycles <= '0;
            else if ((mode == M_HAZARD) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + PCW'(1);
        end
    end

endmodule
